tri_host_driver: RTL and testbench
==================================

Name: tri_host_driver

Overview:
- Host-side driver for the right-angled triangle renderer; sits between a command source (CPU/testbench sequencer) and the renderer's nt/xi/yi input and busy/po/xo/yo output.
- Accepts one triangle (three 3-bit vertices) per command and serialises it onto the renderer's vertex interface.
- Collects every rendered pixel into an 8x8 bitmap framebuffer and counts distinct pixels.
- Signals completion or timeout to the command source.

Parameters:
- TIMEOUT, 1024, maximum cycles allowed in WAIT_BUSY and COLLECT before abort (each state counted separately).
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  command strobe; vertices are sampled when start=1 and ready=1
- v0x, v0y, v1x, v1y, v2x, v2y  in  3 each  triangle vertices (v0 first)
- ready  out  1  driver idle, can accept start
- done  out  1  one-cycle pulse at command completion
- err_timeout  out  1  sticky until next accepted start; set on timeout
- fb  out  64  framebuffer; bit index = y*8+x
- pix_cnt  out  7  number of distinct pixels set in fb (0..64)
- r_nt  out  1  to renderer: new-triangle strobe
- r_xi, r_yi  out  3 each  to renderer: vertex coordinates
- r_busy  in  1  from renderer
- r_po  in  1  from renderer: pixel valid
- r_xo, r_yo  in  3 each  from renderer: pixel coordinates

Behaviour:
- Reset values: ready=1, done=0, err_timeout=0, fb=0, pix_cnt=0, r_nt=0, r_xi=0, r_yi=0; state=IDLE. Reset mid-operation aborts immediately; no partial state survives.
- All outputs are registered.
- IDLE:
  - ready=1.
  - start accepted: latch vertices, clear fb, pix_cnt and err_timeout, go WAIT_IDLE.
  - start while not in IDLE is ignored.
- WAIT_IDLE: ready=0; stay while r_busy=1; go SEND0 when r_busy=0.
- SEND0: r_nt=1, r_xi/r_yi=v0 for exactly one cycle; go SEND1.
- SEND1: r_nt=0, r_xi/r_yi=v1; go SEND2.
- SEND2: r_xi/r_yi=v2; go WAIT_BUSY.
  - Vertices appear on three consecutive cycles, nt high on the first only.
  - r_xi/r_yi hold the last driven value outside SEND states.
- WAIT_BUSY:
  - Go COLLECT when r_busy=1.
  - Capture r_po pixels here too, because the renderer may emit a pixel the cycle busy rises.
  - Timeout counter is cleared on entry; at TIMEOUT cycles, set err_timeout and go DONE.
- COLLECT:
  - Every cycle with r_po=1: set fb[r_yo*8+r_xo].
  - pix_cnt increments only if that bit was 0; duplicate pixels do not count.
  - First cycle with r_busy=0: still capture r_po of that cycle, then go DONE.
  - Counter cleared on entry; at TIMEOUT cycles, set err_timeout and go DONE.
- DONE: done=1 for one cycle; go IDLE. fb and pix_cnt hold until the next accepted start.
- Latency: start to r_nt=1 is 2 cycles when r_busy=0 at start.
- pix_cnt saturates naturally at 64; there is no wrap because only new bits increment it.
- r_po=1 outside WAIT_BUSY/COLLECT is ignored.

Optional Feature:
- Macro TRI_HOST_BBOX_CHECK_EN.
- Defined:
  - Adds output err_bbox (1 bit, sticky, cleared on accepted start).
  - err_bbox is set when a captured pixel lies outside the inclusive bounding box min..max of the three latched vertices in x or y.
  - The pixel is still written to fb.
- Undefined: the err_bbox port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic: the bench renderer model fills the triangle from vertices (0,0),(2,0),(2,2), pixels (0,0),(1,0),(2,0),(1,1),(2,1),(2,2).
  - r_nt pulse with (0,0), then (2,0), then (2,2) on consecutive cycles.
  - After done: fb bits {0,1,2,9,10,18} set, pix_cnt=6, err_timeout=0.
- Busy hold-off: r_busy=1 when start is accepted and held for 20 cycles → r_nt stays 0 until 1 cycle after r_busy falls; ready=0 throughout.
- Duplicates: model emits (3,3) three times plus (4,3) → pix_cnt=2, fb bits 27 and 28 set.
- Timeout: TIMEOUT=16 and r_busy never rises → err_timeout=1 and a done pulse 16 cycles after SEND2; fb=0.
- Reset mid-COLLECT: assert reset after 3 pixels → next cycle fb=0, pix_cnt=0, ready=1, r_nt=0. A second start then completes normally.
- With TRI_HOST_BBOX_CHECK_EN: vertices (1,1),(3,1),(3,3), model injects pixel (5,2) → err_bbox=1 and fb bit 21 set. Without the macro, elaboration has no err_bbox port.

Source files
------------

// File: rtl/tri_host_driver.sv
// tri_host_driver: host-side sequencer for the right-angled triangle renderer.
// Latches one triangle per command, serialises its three vertices onto the
// renderer's nt/xi/yi interface, then collects rendered pixels into an 8x8
// bitmap (bit index y*8+x) while counting distinct pixels. Reports
// completion with a one-cycle done pulse and flags renderer stalls with a
// sticky err_timeout.
// Optional build macro TRI_HOST_BBOX_CHECK_EN adds the sticky err_bbox output,
// raised when a captured pixel lies outside the latched vertices' bounding box.
module tri_host_driver #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  v0x,
    input  logic [2:0]  v0y,
    input  logic [2:0]  v1x,
    input  logic [2:0]  v1y,
    input  logic [2:0]  v2x,
    input  logic [2:0]  v2y,
    output logic        ready,
    output logic        done,
    output logic        err_timeout,
`ifdef TRI_HOST_BBOX_CHECK_EN
    output logic        err_bbox,
`endif
    output logic [63:0] fb,
    output logic [6:0]  pix_cnt,
    output logic        r_nt,
    output logic [2:0]  r_xi,
    output logic [2:0]  r_yi,
    input  logic        r_busy,
    input  logic        r_po,
    input  logic [2:0]  r_xo,
    input  logic [2:0]  r_yo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_SEND0,
        S_SEND1,
        S_SEND2,
        S_WAIT_BUSY,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0][2:0]   lx, ly, lx_next, ly_next;
    logic [63:0]       fb_next;
    logic [6:0]        pix_next;
    logic              err_next;
    logic              capture;
    logic [5:0]        pix_idx;

    assign pix_idx = {r_yo, r_xo};

    // Next-state, timeout counter, vertex latch and framebuffer update.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lx_next    = lx;
        ly_next    = ly;
        fb_next    = fb;
        pix_next   = pix_cnt;
        err_next   = err_timeout;
        capture    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    lx_next    = {v2x, v1x, v0x};
                    ly_next    = {v2y, v1y, v0y};
                    fb_next    = '0;
                    pix_next   = '0;
                    err_next   = 1'b0;
                    state_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!r_busy) state_next = S_SEND0;
            end
            S_SEND0: state_next = S_SEND1;
            S_SEND1: state_next = S_SEND2;
            S_SEND2: begin
                cnt_next   = '0;
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The renderer may emit its first pixel on the cycle busy rises.
                capture = r_po;
                if (r_busy) begin
                    cnt_next   = '0;
                    state_next = S_COLLECT;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_COLLECT: begin
                capture = r_po;
                if (!r_busy) begin
                    state_next = S_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Only a previously clear bit counts, so pix_cnt tops out at 64.
        if (capture && !fb[pix_idx]) begin
            fb_next[pix_idx] = 1'b1;
            pix_next         = pix_cnt + 7'd1;
        end
    end

    // State and datapath registers; interface outputs are registered decodes
    // of the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lx          <= '0;
            ly          <= '0;
            fb          <= '0;
            pix_cnt     <= '0;
            err_timeout <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            r_nt        <= 1'b0;
            r_xi        <= '0;
            r_yi        <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            lx          <= lx_next;
            ly          <= ly_next;
            fb          <= fb_next;
            pix_cnt     <= pix_next;
            err_timeout <= err_next;
            ready       <= (state_next == S_IDLE);
            done        <= (state_next == S_DONE);
            r_nt        <= (state_next == S_SEND0);
            case (state_next)
                S_SEND0: begin
                    r_xi <= lx[0];
                    r_yi <= ly[0];
                end
                S_SEND1: begin
                    r_xi <= lx[1];
                    r_yi <= ly[1];
                end
                S_SEND2: begin
                    r_xi <= lx[2];
                    r_yi <= ly[2];
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TRI_HOST_BBOX_CHECK_EN
    logic [2:0] bx_min, bx_max, by_min, by_max;
    logic       bbox_next;

    // Flag captured pixels lying outside the latched vertices' bounding box.
    always_comb begin
        bx_min = lx[0];
        bx_max = lx[0];
        by_min = ly[0];
        by_max = ly[0];
        for (int unsigned i = 1; i < 3; i++) begin
            if (lx[i] < bx_min) bx_min = lx[i];
            if (lx[i] > bx_max) bx_max = lx[i];
            if (ly[i] < by_min) by_min = ly[i];
            if (ly[i] > by_max) by_max = ly[i];
        end
        bbox_next = err_bbox;
        if (state == S_IDLE && start) begin
            bbox_next = 1'b0;
        end else if (capture && (r_xo < bx_min || r_xo > bx_max ||
                                 r_yo < by_min || r_yo > by_max)) begin
            bbox_next = 1'b1;
        end
    end

    // Sticky bounding-box error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_bbox <= 1'b0;
        else       err_bbox <= bbox_next;
    end
`endif

endmodule

// File: tb/tb_tri_host_driver.sv
// Self-checking bench for tri_host_driver: a table of directed transactions,
// a reset-mid-collect sequence and randomized transactions, all checked
// against a bitmap/popcount model of the pixel stream.
`timescale 1ns/1ps
module tb_tri_host_driver;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  v0x, v0y, v1x, v1y, v2x, v2y;
    logic        ready, done, err_timeout;
    logic [63:0] fb;
    logic [6:0]  pix_cnt;
    logic        r_nt;
    logic [2:0]  r_xi, r_yi;
    logic        r_busy, r_po;
    logic [2:0]  r_xo, r_yo;
`ifdef TRI_HOST_BBOX_CHECK_EN
    logic        err_bbox;
`endif

    tri_host_driver #(.TIMEOUT(TMO), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
        .ready(ready), .done(done), .err_timeout(err_timeout),
`ifdef TRI_HOST_BBOX_CHECK_EN
        .err_bbox(err_bbox),
`endif
        .fb(fb), .pix_cnt(pix_cnt),
        .r_nt(r_nt), .r_xi(r_xi), .r_yi(r_yi),
        .r_busy(r_busy), .r_po(r_po), .r_xo(r_xo), .r_yo(r_yo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pixel stream for the current transaction, each entry {y, x}.
    logic [5:0] pq[$];

    typedef struct {
        logic [17:0]     verts;   // {v0x,v0y,v1x,v1y,v2x,v2y}
        int              npix;
        logic [7:0][5:0] pix;     // pix[i] = {y, x}
        int              holdoff;
        int              wait_cyc;
        int              mode;    // 0 normal, 1 busy never rises, 2 busy stuck high
        bit              tail;    // last pixel arrives on the busy-fall cycle
        logic [63:0]     exp_fb;
        int              exp_cnt;
        bit              exp_tmo;
        bit              exp_bbox;
    } txn_t;

    txn_t tbl[7];

    task automatic check(input string tag, input string what,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_junk();
        r_po = 1'($urandom);
        r_xo = 3'($urandom);
        r_yo = 3'($urandom);
    endtask

    // Model: bitmap is the union of all pixels in the stream.
    function automatic logic [63:0] model_fb();
        logic [63:0] m = '0;
        int idx;
        foreach (pq[i]) begin
            idx = int'(pq[i][5:3]) * 8 + int'(pq[i][2:0]);
            m[idx] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit model_bbox(input logic [17:0] verts);
        int xs[3];
        int ys[3];
        int xmin, xmax, ymin, ymax, x, y;
        bit outside = 1'b0;
        xs[0] = int'(verts[17:15]); ys[0] = int'(verts[14:12]);
        xs[1] = int'(verts[11:9]);  ys[1] = int'(verts[8:6]);
        xs[2] = int'(verts[5:3]);   ys[2] = int'(verts[2:0]);
        xmin = 7; xmax = 0; ymin = 7; ymax = 0;
        for (int i = 0; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        foreach (pq[i]) begin
            x = int'(pq[i][2:0]);
            y = int'(pq[i][5:3]);
            if (x < xmin || x > xmax || y < ymin || y > ymax) outside = 1'b1;
        end
        return outside;
    endfunction

    task automatic load_pq(input logic [7:0][5:0] pix, input int npix);
        pq.delete();
        for (int i = 0; i < npix; i++) pq.push_back(pix[i]);
    endtask

    task automatic run_txn(input logic [17:0] verts, input int h, input int wait_cyc,
                           input int mode, input bit tail, input bit gaps,
                           input logic [63:0] efb, input int ecnt, input bit etmo,
                           input bit ebbox, input string tag);
        int k, cnt, n_body, ready_bad;
        logic [2:0] ex0, ey0, ex1, ey1, ex2, ey2;
        {ex0, ey0, ex1, ey1, ex2, ey2} = verts;
        ready_bad = 0;

        step();
        check(tag, "ready_idle", 64'(ready), 64'(1));
        {v0x, v0y, v1x, v1y, v2x, v2y} = verts;
        start  = 1'b1;
        r_busy = (h > 0);
        drive_junk();
        k = 0;
        while (1) begin
            step();
            k++;
            if (k == 1) begin
                start = 1'b0;
                {v0x, v0y, v1x, v1y, v2x, v2y} = 18'($urandom);
            end
            if (r_nt === 1'b1 || k > 60) break;
            if (ready !== 1'b0) ready_bad++;
            r_busy = (k < h);
            drive_junk();
        end
        check(tag, "nt_latency", 64'(k), 64'(((h > 1) ? h : 1) + 1));
        check(tag, "ready_low", 64'(ready_bad), 64'(0));

        check(tag, "send0", {61'd0, r_nt, r_xi, r_yi} >> 0, {57'd0, 1'b1, ex0, ey0});
        drive_junk();
        step();
        check(tag, "send1", {57'd0, r_nt, r_xi, r_yi}, {57'd0, 1'b0, ex1, ey1});
        drive_junk();
        step();
        check(tag, "send2", {57'd0, r_nt, r_xi, r_yi}, {57'd0, 1'b0, ex2, ey2});
        drive_junk();
        r_busy = 1'b0;
        step();
        cnt = 1;

        if (mode == 1) begin
            r_po = 1'b0;
            r_busy = 1'b0;
            while (done !== 1'b1 && cnt < 100) begin
                step();
                cnt++;
            end
            // TIMEOUT cycles spent waiting, done in the cycle after.
            check(tag, "tmo_cycles", 64'(cnt), 64'(TMO + 1));
        end else begin
            for (int w = 0; w < wait_cyc; w++) begin
                r_busy = 1'b0;
                r_po   = 1'b0;
                step();
            end
            n_body = pq.size() - (tail ? 1 : 0);
            if (n_body == 0) begin
                r_busy = 1'b1;
                r_po   = 1'b0;
                step();
            end
            for (int i = 0; i < n_body; i++) begin
                r_busy = 1'b1;
                r_po   = 1'b1;
                {r_yo, r_xo} = pq[i];
                step();
                if (gaps && $urandom_range(0, 2) == 0) begin
                    r_po = 1'b0;
                    r_xo = 3'($urandom);
                    r_yo = 3'($urandom);
                    step();
                end
            end
            if (mode == 0) begin
                r_busy = 1'b0;
                r_po   = tail;
                if (tail) {r_yo, r_xo} = pq[pq.size() - 1];
                step();
                check(tag, "done_pulse", 64'(done), 64'(1));
            end else begin
                r_busy = 1'b1;
                r_po   = 1'b0;
                cnt = 0;
                while (done !== 1'b1 && cnt < 100) begin
                    step();
                    cnt++;
                end
                check(tag, "done_seen", 64'(done), 64'(1));
            end
        end

        check(tag, "fb", fb, efb);
        check(tag, "pix_cnt", 64'(pix_cnt), 64'(ecnt));
        check(tag, "err_timeout", 64'(err_timeout), 64'(etmo));
`ifdef TRI_HOST_BBOX_CHECK_EN
        check(tag, "err_bbox", 64'(err_bbox), 64'(ebbox));
`endif
        r_busy = 1'b0;
        drive_junk();
        step();
        check(tag, "after_done", {61'd0, done, ready, err_timeout}, {61'd0, 1'b0, 1'b1, etmo});
        check(tag, "fb_hold", fb, efb);
        r_po = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] verts;
        logic [63:0] efb;
        int n, kk;
        bit narrow;
        logic [2:0] px, py;

        // Directed transactions: pixels written as 6'o<y><x>, vertices as
        // 18'o<v0x v0y v1x v1y v2x v2y>.
        tbl[0] = '{18'o002022, 6, {6'o00, 6'o00, 6'o22, 6'o12, 6'o11, 6'o02, 6'o01, 6'o00},
                   0, 1, 0, 1'b1, 64'h0000_0000_0004_0607, 6, 1'b0, 1'b0};
        tbl[1] = '{18'o002022, 6, {6'o00, 6'o00, 6'o22, 6'o12, 6'o11, 6'o02, 6'o01, 6'o00},
                   20, 0, 0, 1'b0, 64'h0000_0000_0004_0607, 6, 1'b0, 1'b0};
        tbl[2] = '{18'o334344, 4, {6'o00, 6'o00, 6'o00, 6'o00, 6'o34, 6'o33, 6'o33, 6'o33},
                   0, 2, 0, 1'b1, 64'h0000_0000_1800_0000, 2, 1'b0, 1'b0};
        tbl[3] = '{18'o125256, 0, '0,
                   0, 0, 1, 1'b0, 64'h0, 0, 1'b1, 1'b0};
        tbl[4] = '{18'o007077, 2, {6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o70, 6'o07},
                   0, TMO - 1, 0, 1'b0, 64'h0100_0000_0000_0080, 2, 1'b0, 1'b0};
        tbl[5] = '{18'o077770, 2, {6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o70, 6'o77},
                   0, 0, 2, 1'b0, 64'h8100_0000_0000_0000, 2, 1'b1, 1'b0};
        tbl[6] = '{18'o113133, 1, {6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o25},
                   0, 0, 0, 1'b0, 64'h0000_0000_0020_0000, 1, 1'b0, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        {v0x, v0y, v1x, v1y, v2x, v2y} = '0;
        r_busy = 1'b0;
        r_po   = 1'b0;
        r_xo   = '0;
        r_yo   = '0;
        step();
        step();
        check("reset", "ctrl", {55'd0, ready, done, err_timeout, r_nt, r_xi, r_yi},
              {55'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0});
        check("reset", "fb", fb, 64'h0);
        check("reset", "pix_cnt", 64'(pix_cnt), 64'(0));
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            load_pq(tbl[t].pix, tbl[t].npix);
            run_txn(tbl[t].verts, tbl[t].holdoff, tbl[t].wait_cyc, tbl[t].mode,
                    tbl[t].tail, 1'b0, tbl[t].exp_fb, tbl[t].exp_cnt,
                    tbl[t].exp_tmo, tbl[t].exp_bbox, $sformatf("tbl%0d", t));
        end

        // Reset while collecting: everything returns to idle immediately.
        step();
        {v0x, v0y, v1x, v1y, v2x, v2y} = 18'o002022;
        start = 1'b1;
        step();
        start = 1'b0;
        kk = 0;
        while (r_nt !== 1'b1 && kk < 20) begin
            step();
            kk++;
        end
        check("rst_mid", "nt_seen", 64'(r_nt), 64'(1));
        step();
        step();
        r_busy = 1'b1;
        r_po   = 1'b0;
        step();
        r_po = 1'b1;
        {r_yo, r_xo} = 6'o00; step();
        {r_yo, r_xo} = 6'o01; step();
        {r_yo, r_xo} = 6'o11; step();
        check("rst_mid", "pix_before", 64'(pix_cnt), 64'(3));
        reset = 1'b1;
        #1;
        check("rst_mid", "ctrl", {59'd0, ready, done, err_timeout, r_nt, 1'b0},
              {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_mid", "fb", fb, 64'h0);
        check("rst_mid", "pix_cnt", 64'(pix_cnt), 64'(0));
        step();
        reset  = 1'b0;
        r_busy = 1'b0;
        r_po   = 1'b0;
        load_pq(tbl[0].pix, tbl[0].npix);
        run_txn(tbl[0].verts, 0, 0, 0, 1'b1, 1'b0, tbl[0].exp_fb, tbl[0].exp_cnt,
                1'b0, 1'b0, "post_rst");

        // Randomized transactions against the bitmap model.
        for (int t = 0; t < 12; t++) begin
            verts = 18'($urandom);
            pq.delete();
            n = $urandom_range(1, 6);
            narrow = 1'($urandom);
            for (int j = 0; j < n; j++) begin
                px = narrow ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
                py = narrow ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
                pq.push_back({py, px});
            end
            efb = model_fb();
            run_txn(verts, $urandom_range(0, 3), $urandom_range(0, 4), 0,
                    1'($urandom), 1'b1, efb, $countones(efb), 1'b0,
                    model_bbox(verts), $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
